// File: rtl/contador_pkg.sv
// Shared encodings for the contador_modos counter/shift register:
// operation-select codes and load-then-run FSM states.
package contador_pkg;

    typedef enum logic [1:0] {
        MODO_UP    = 2'b00,
        MODO_DOWN  = 2'b01,
        MODO_SHIFT = 2'b10,
        MODO_LOAD  = 2'b11
    } modo_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOADED = 2'b01,
        ST_RUN    = 2'b10
    } state_e;

endpackage

// File: rtl/contador_next.sv
// Combinational next-value logic: next count, ripple carry/borrow and shift-out bit.
// Build option SATURATE_EN: up/down stop at the limits instead of wrapping.
module contador_next
    import contador_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             enable_i,
    input  modo_e            modo_i,
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             serial_in_i,
    output logic [WIDTH-1:0] count_d_o,
    output logic             rco_o,
    output logic             shift_bit_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic at_max_s;
    logic at_zero_s;
    logic limit_s;

    assign at_max_s  = &count_i;
    assign at_zero_s = ~|count_i;

    // Next count and limit detection by operation mode
    always_comb begin
        count_d_o   = count_i;
        limit_s     = 1'b0;
        shift_bit_o = count_i[0];
        case (modo_i)
            MODO_UP: begin
                limit_s = at_max_s;
`ifdef SATURATE_EN
                if (at_max_s) count_d_o = count_i;
                else          count_d_o = count_i + ONE;
`else
                count_d_o = count_i + ONE;
`endif
            end
            MODO_DOWN: begin
                limit_s = at_zero_s;
`ifdef SATURATE_EN
                if (at_zero_s) count_d_o = count_i;
                else           count_d_o = count_i - ONE;
`else
                count_d_o = count_i - ONE;
`endif
            end
            MODO_SHIFT: count_d_o = {serial_in_i, count_i[WIDTH-1:1]};
            MODO_LOAD:  count_d_o = d_i;
            default:    count_d_o = count_i;
        endcase
    end

    assign rco_o = enable_i & limit_s;

endmodule

// File: rtl/contador_modos.sv
// Up/down counter, shift register and parallel load with cascadable rco and a
// load-then-run busy handshake. Build option SATURATE_EN selects saturating counts.
module contador_modos
    import contador_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] d,
    input  logic             serial_in,
    output logic [WIDTH-1:0] count,
    output logic             rco,
    output logic             serial_out,
    output logic             busy
);

    modo_e            modo_s;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             shift_bit_s;
    logic             serial_out_q;
    logic             busy_q;
    state_e           state_q;

    assign modo_s = modo_e'(modo);

    contador_next #(.WIDTH(WIDTH)) u_next (
        .enable_i    (enable),
        .modo_i      (modo_s),
        .count_i     (count_q),
        .d_i         (d),
        .serial_in_i (serial_in),
        .count_d_o   (count_d),
        .rco_o       (rco),
        .shift_bit_o (shift_bit_s)
    );

    // Count/shift registers plus the load-then-run FSM with registered busy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q      <= INIT;
            serial_out_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
        end else if (enable) begin
            count_q <= count_d;
            if (modo_s == MODO_SHIFT) serial_out_q <= shift_bit_s;
            case (state_q)
                ST_IDLE: begin
                    if (modo_s == MODO_LOAD) begin
                        state_q <= ST_LOADED;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOADED: begin
                    if (modo_s == MODO_UP || modo_s == MODO_DOWN) begin
                        state_q <= ST_RUN;
                    end else if (modo_s == MODO_SHIFT) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // rco is only ever high for an up/down edge at the limit
                    if (modo_s == MODO_LOAD) begin
                        state_q <= ST_LOADED;
                    end else if (rco) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count      = count_q;
    assign serial_out = serial_out_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_contador_modos.sv
// Scoreboard bench for contador_modos: directed scenarios then random vectors
// against an arithmetic reference model; a monitor process checks the DUT.
module tb_contador_modos;

    localparam int               W     = 4;
    localparam int               MAXV  = (1 << W) - 1;
    localparam logic [W-1:0]     INITV = 4'd0;

    logic         clk;
    logic         reset;
    logic         enable;
    logic [1:0]   modo;
    logic [W-1:0] d;
    logic         serial_in;
    logic [W-1:0] count;
    logic         rco;
    logic         serial_out;
    logic         busy;

    contador_modos #(.WIDTH(W), .INIT(INITV)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .modo       (modo),
        .d          (d),
        .serial_in  (serial_in),
        .count      (count),
        .rco        (rco),
        .serial_out (serial_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rco;
        int cnt;
        int so;
        int busy;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   fails   = 0;
    int   checks  = 0;

    int   m_cnt;
    int   m_so;
    bit   m_armed;
    bit   m_running;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt     = int'(INITV);
        m_so      = 0;
        m_armed   = 1'b0;
        m_running = 1'b0;
    endtask

    // Drive one vector, advance the reference model, queue what the DUT must show
    task automatic apply(input bit en, input int md, input int dv, input bit si);
        exp_t e;
        @(posedge clk);
        #2;
        enable    = en;
        modo      = md[1:0];
        d         = dv[W-1:0];
        serial_in = si;
        e.rco = (en && ((md == 0 && m_cnt == MAXV) || (md == 1 && m_cnt == 0))) ? 1 : 0;
        if (en) begin
            case (md)
`ifdef SATURATE_EN
                0: m_cnt = (m_cnt == MAXV) ? MAXV : m_cnt + 1;
                1: m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
`else
                0: m_cnt = (m_cnt + 1) % (MAXV + 1);
                1: m_cnt = (m_cnt + MAXV) % (MAXV + 1);
`endif
                2: begin
                    m_so  = m_cnt % 2;
                    m_cnt = m_cnt / 2 + (si ? (MAXV + 1) / 2 : 0);
                end
                default: m_cnt = dv % (MAXV + 1);
            endcase
            if (md == 3) begin
                m_armed   = 1'b1;
                m_running = 1'b0;
            end else if (m_armed) begin
                m_armed   = 1'b0;
                m_running = (md < 2);
            end else if (m_running && e.rco == 1) begin
                m_running = 1'b0;
            end
        end
        e.cnt  = m_cnt;
        e.so   = m_so;
        e.busy = (m_armed || m_running) ? 1 : 0;
        q.push_back(e);
        vectors++;
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock
    task automatic do_reset();
        @(posedge clk);
        #3;
        enable = 1'b0;
        reset  = 1'b0;
        #1;
        model_reset();
        chk("reset_count", 32'(count), 32'(m_cnt));
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_serial_out", 32'(serial_out), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    // Monitor: rco before the edge, registered outputs just after it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rco", 32'(rco), 32'(e.rco));
                @(posedge clk);
                #1;
                chk("count", 32'(count), 32'(e.cnt));
                chk("serial_out", 32'(serial_out), 32'(e.so));
                chk("busy", 32'(busy), 32'(e.busy));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wait_cycles;
        reset     = 1'b0;
        enable    = 1'b0;
        modo      = 2'b00;
        d         = '0;
        serial_in = 1'b0;
        model_reset();
        #10;
        chk("initial_reset_count", 32'(count), 32'(INITV));
        chk("initial_reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Up count through the wrap
        for (int i = 0; i < 17; i++) apply(1'b1, 0, 0, 1'b0);
        // Down wrap after load, busy through the handshake
        apply(1'b1, 3, 2, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b1, 1, 0, 1'b0);
        // Enable hold
        apply(1'b1, 3, 5, 1'b0);
        for (int i = 0; i < 5; i++) apply(1'b0, 0, 0, 1'b0);
        apply(1'b1, 0, 0, 1'b0);
        // Shift right of 1011
        apply(1'b1, 3, 11, 1'b0);
        for (int i = 0; i < 4; i++) apply(1'b1, 2, 0, 1'b0);
        // Async reset mid-RUN at count 9
        apply(1'b1, 3, 8, 1'b0);
        apply(1'b1, 0, 0, 1'b0);
        do_reset();
        // Limit behaviour from 14 (wrap or saturate by build)
        apply(1'b1, 3, 14, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b1, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b1, 1, 0, 1'b0);
        apply(1'b1, 3, 1, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b1, 1, 0, 1'b0);

        // Random traffic with occasional async resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            apply($urandom_range(0, 7) != 0, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, MAXV)), $urandom_range(0, 1) == 1);
        end

        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        #3;
        if (q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        if (checks == 0) begin
            fails++;
            $display("FAIL no_checks: got 0 comparisons, expected more than 0");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
